// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted writeback FIFO between the D-cache and data memory; define WBUF_FWD_EN to forward fills from buffered lines
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {M_IDLE, M_DRAIN, M_READ, M_RESP} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic push, pop, rd_req;
  // DEPTH is a power of two, so the count MSB alone marks a full buffer
  assign push = mem_write_D && !mem_ready_D && !count[PW];
  assign pop = (state == M_DRAIN) && mem_ready;
  // a simultaneous write takes precedence, and the request held during the ack cycle is ignored
  assign rd_req = mem_read_D && !mem_write_D && !mem_ready_D;
`ifdef WBUF_FWD_EN
  logic fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0] idx;
  // Scan valid entries oldest to newest so the newest matching line wins
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < count && addr_q[idx] == mem_addr_D) begin
        fwd_hit = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
`endif
  // Line storage; entries at or beyond count are don't-care, so no reset is needed
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr] <= mem_addr_D;
      data_q[wr_ptr] <= mem_wdata_D;
    end
  // FIFO bookkeeping, cache acknowledge and memory-side FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= M_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      mem_ready_D <= 1'b0;
      mem_rdata_D <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      mem_ready_D <= push;
      case (state)
        M_IDLE: begin
`ifdef WBUF_FWD_EN
          if (rd_req && fwd_hit) begin
            mem_rdata_D <= fwd_data;
            mem_ready_D <= 1'b1;
            state <= M_RESP;
          end else if (rd_req) begin
`else
          if (rd_req && count == '0) begin
`endif
            mem_read <= 1'b1;
            mem_addr <= mem_addr_D;
            state <= M_READ;
          end else if (count != '0) begin
            mem_write <= 1'b1;
            mem_addr <= addr_q[rd_ptr];
            mem_wdata <= data_q[rd_ptr];
            state <= M_DRAIN;
          end
        end
        M_DRAIN:
          if (mem_ready) begin
            mem_write <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            state <= M_IDLE;
          end
        M_READ:
          if (mem_ready) begin
            mem_read <= 1'b0;
            mem_addr <= '0;
            mem_rdata_D <= mem_rdata;
            mem_ready_D <= 1'b1;
            state <= M_RESP;
          end
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: scoreboard bench for the posted D-cache write buffer (WBUF_FWD_EN selects forwarding expectations)
module tb_dcache_write_buffer;
  localparam int AW = 28;
  localparam int DW = 128;
  logic clk = 1'b0;
  logic rst_n;
  logic mem_read_D, mem_write_D;
  logic [AW-1:0] mem_addr_D;
  logic [DW-1:0] mem_wdata_D, mem_rdata_D;
  logic mem_ready_D;
  logic mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic mem_ready;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {bit is_rd; logic [DW-1:0] data;} resp_t;
  wr_t exp_wr[$];
  resp_t exp_resp[$];
  logic [DW-1:0] store [logic [AW-1:0]];
  int tests = 0, fails = 0;
  int mem_delay = 2, wait_cnt = 0, wr_done = 0, rd_cnt = 0, rd_wr_done = 0;
  bit prev_rdy = 1'b0;

  dcache_write_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill_val(input logic [AW-1:0] a);
    return {4{4'hF, a}};
  endfunction

  function automatic logic [DW-1:0] line(input int i);
    return {4{32'(i) + 32'hD000_0000}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cache_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat, output int done_at_ack);
    exp_wr.push_back('{a, d});
    exp_resp.push_back('{1'b0, '0});
    mem_addr_D = a;
    mem_wdata_D = d;
    mem_write_D = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready_D && lat < 500);
    done_at_ack = wr_done;
    if (!mem_ready_D) begin
      tests++;
      fails++;
      $display("FAIL write_ack_timeout: addr %h got no ack required ack", a);
    end
    mem_write_D = 1'b0;
    @(negedge clk);
  endtask

  task automatic cache_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    exp_resp.push_back('{1'b1, d});
    mem_addr_D = a;
    mem_read_D = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready_D && n < 500);
    if (!mem_ready_D) begin
      tests++;
      fails++;
      $display("FAIL read_ack_timeout: addr %h got no ack required ack", a);
    end
    mem_read_D = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || mem_write) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, DW'(exp_wr.size()), '0);
  endtask

  // memory model: acknowledges after mem_delay cycles and checks drained lines in FIFO order
  initial begin
    wr_t w;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!(mem_write || mem_read)) wait_cnt = 0;
      else if (wait_cnt < mem_delay) wait_cnt++;
      else begin
        wait_cnt = 0;
        mem_ready = 1'b1;
        if (mem_write) begin
          tests++;
          wr_done++;
          store[mem_addr] = mem_wdata;
          if (exp_wr.size() == 0) begin
            fails++;
            $display("FAIL mem_write_unexpected: got addr %h required none", mem_addr);
          end else begin
            w = exp_wr.pop_front();
            if (w.addr !== mem_addr || w.data !== mem_wdata) begin
              fails++;
              $display("FAIL mem_write_order: got %h/%h required %h/%h", mem_addr, mem_wdata, w.addr, w.data);
            end
          end
        end else begin
          rd_cnt++;
          rd_wr_done = wr_done;
          mem_rdata = store.exists(mem_addr) ? store[mem_addr] : fill_val(mem_addr);
        end
      end
    end
  end

  // cache-side monitor: every ack pops one expected response
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (mem_ready_D) begin
        tests++;
        if (prev_rdy) begin
          fails++;
          $display("FAIL ready_back_to_back: got two ready cycles required one");
        end else if (exp_resp.size() == 0) begin
          fails++;
          $display("FAIL ready_unexpected: got ready required none");
        end else begin
          r = exp_resp.pop_front();
          if (r.is_rd && mem_rdata_D !== r.data) begin
            fails++;
            $display("FAIL read_data: got %h required %h", mem_rdata_D, r.data);
          end
        end
      end
      prev_rdy = mem_ready_D;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, ack_done, base, rbase;
    rst_n = 1'b0;
    mem_read_D = 1'b0;
    mem_write_D = 1'b0;
    mem_addr_D = '0;
    mem_wdata_D = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", DW'(mem_read), '0);
    check("rst_mem_write", DW'(mem_write), '0);
    check("rst_mem_addr", DW'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_ready_D", DW'(mem_ready_D), '0);
    check("rst_rdata_D", mem_rdata_D, '0);
    rst_n = 1'b1;
    @(negedge clk);

    mem_delay = 3;
    cache_write(28'h0000010, {16{8'hA5}}, lat, ack_done);
    check("single_ack_lat", DW'(lat), DW'(1));
    wait_drained("single_drain");

    mem_delay = 10;
    base = wr_done;
    for (int i = 1; i <= 4; i++) begin
      cache_write(AW'(i), line(i), lat, ack_done);
      check($sformatf("prompt_ack_lat%0d", i), DW'(lat), DW'(1));
    end
    cache_write(AW'(5), line(5), lat, ack_done);
    check("full_ack_after_first_drain", DW'(ack_done - base), DW'(1));
    wait_drained("five_drain");

    mem_delay = 4;
    rbase = rd_cnt;
    cache_write(28'h20, line(32'hD1), lat, ack_done);
    cache_write(28'h20, line(32'hD2), lat, ack_done);
    cache_read(28'h20, line(32'hD2));
`ifdef WBUF_FWD_EN
    check("fwd_no_mem_read", DW'(rd_cnt - rbase), DW'(0));
`else
    check("drain_then_mem_read", DW'(rd_cnt - rbase), DW'(1));
`endif
    wait_drained("same_addr_drain");

    mem_delay = 6;
    base = wr_done;
    rbase = rd_cnt;
    cache_write(28'h40, line(32'h40), lat, ack_done);
    cache_write(28'h41, line(32'h41), lat, ack_done);
    cache_read(28'h30, fill_val(28'h30));
    check("miss_one_mem_read", DW'(rd_cnt - rbase), DW'(1));
`ifdef WBUF_FWD_EN
    check("miss_writes_before_read", DW'(rd_wr_done - base), DW'(1));
`else
    check("miss_writes_before_read", DW'(rd_wr_done - base), DW'(2));
`endif
    wait_drained("miss_drain");
    check("rdata_held", mem_rdata_D, fill_val(28'h30));

    mem_delay = 20;
    for (int i = 0; i < 3; i++) cache_write(AW'(32'h50 + i), line(32'h50 + i), lat, ack_done);
    check("drain_active_before_rst", DW'(mem_write), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_write", DW'(mem_write), '0);
    check("arst_mem_addr", DW'(mem_addr), '0);
    check("arst_mem_wdata", mem_wdata, '0);
    check("arst_rdata_D", mem_rdata_D, '0);
    check("arst_ready_D", DW'(mem_ready_D), '0);
    exp_wr.delete();
    base = wr_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("no_writes_after_rst", DW'(wr_done - base), DW'(0));
    check("idle_after_rst", DW'(mem_write), '0);

    mem_delay = 8;
    base = wr_done;
    for (int i = 0; i < 4; i++) cache_write(AW'(32'h60 + i), line(32'h60 + i), lat, ack_done);
    cache_write(28'h64, line(32'h64), lat, ack_done);
    check("full_push_after_pop1", DW'(ack_done - base), DW'(1));
    cache_write(28'h65, line(32'h65), lat, ack_done);
    check("full_push_after_pop2", DW'(ack_done - base), DW'(2));
    wait_drained("full_drain");
    check("full_total_writes", DW'(wr_done - base), DW'(6));
    check("resp_queue_empty", DW'(exp_resp.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
